// File: rtl/msi_snoop_arbiter_if.sv
// rtl/msi_snoop_arbiter_if.sv - request/snoop/grant bundle between the two cache controllers and the arbiter
interface msi_snoop_arbiter_if;
  logic [1:0]  read_miss;
  logic [1:0]  write_miss;
  logic [1:0]  invalidate;
  logic [1:0]  evict_req;
  logic [12:0] bico0;
  logic [12:0] bico1;
  logic [1:0]  cpu_search_found;
  logic [15:0] send_other_proc_data0;
  logic [15:0] send_other_proc_data1;
  logic        u_rdy;
  logic [1:0]  grant;
  logic [1:0]  cpu_search;
  logic [12:0] boci0;
  logic [12:0] boci1;
  logic [15:0] other_proc_data;
  logic [1:0]  cpu_datasel0;
  logic [1:0]  cpu_datasel1;
  logic [1:0]  cpu_dmem_permission;
  logic [1:0]  invalidate_from_other_cpu;

  modport master (
    output read_miss, write_miss, invalidate, evict_req, bico0, bico1,
           cpu_search_found, send_other_proc_data0, send_other_proc_data1, u_rdy,
    input  grant, cpu_search, boci0, boci1, other_proc_data, cpu_datasel0,
           cpu_datasel1, cpu_dmem_permission, invalidate_from_other_cpu
  );

  modport slave (
    input  read_miss, write_miss, invalidate, evict_req, bico0, bico1,
           cpu_search_found, send_other_proc_data0, send_other_proc_data1, u_rdy,
    output grant, cpu_search, boci0, boci1, other_proc_data, cpu_datasel0,
           cpu_datasel1, cpu_dmem_permission, invalidate_from_other_cpu
  );
endinterface

// File: rtl/msi_snoop_arbiter.sv
// rtl/msi_snoop_arbiter.sv - two-core MSI shared-bus arbiter with snoop forwarding and dmem permission
// Optional: ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default fixed priority, core 0 wins).
module msi_snoop_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  msi_snoop_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SNOOP, FWD, MEM, INVAL, DONE} state_t;
  typedef enum logic [1:0] {K_INV, K_WR, K_RD, K_EV} kind_t;

  state_t      state;
  kind_t       kind;
  logic        r;
  logic [1:0]  grant_q;
  logic [1:0]  cpu_search_q;
  logic [12:0] boci0_q;
  logic [12:0] boci1_q;
  logic [15:0] other_proc_data_q;
  logic [1:0]  datasel0_q;
  logic [1:0]  datasel1_q;
  logic [1:0]  perm_q;
  logic [1:0]  inval_q;

  logic [1:0]  pend;
  logic        pick;
  kind_t       pick_kind;
  logic [12:0] pick_addr;
  logic        found_o;
  logic [15:0] data_o;

  function automatic logic [1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  assign pend = bus.read_miss | bus.write_miss | bus.invalidate | bus.evict_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    pick = (pend == 2'b10);
    if (pend == 2'b11) pick = ~last_grant;
  end

  // Tracks every grant pulse, including the Mealy grant out of MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_grant <= 1'b1;
    else if (bus.grant != 2'b00) last_grant <= bus.grant[1];
  end
`else
  always_comb begin
    pick = (pend == 2'b10);
  end
`endif

  always_comb begin
    pick_kind = K_EV;
    if (bus.invalidate[pick])      pick_kind = K_INV;
    else if (bus.write_miss[pick]) pick_kind = K_WR;
    else if (bus.read_miss[pick])  pick_kind = K_RD;
  end

  assign pick_addr = pick ? bus.bico1 : bus.bico0;
  assign found_o   = bus.cpu_search_found[~r];
  assign data_o    = r ? bus.send_other_proc_data0 : bus.send_other_proc_data1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      kind              <= K_RD;
      r                 <= 1'b0;
      grant_q           <= 2'b00;
      cpu_search_q      <= 2'b00;
      boci0_q           <= '0;
      boci1_q           <= '0;
      other_proc_data_q <= '0;
      datasel0_q        <= 2'b00;
      datasel1_q        <= 2'b00;
      perm_q            <= 2'b00;
      inval_q           <= 2'b00;
    end else begin
      // Strobes are single-cycle; only permission and held data persist.
      grant_q      <= 2'b00;
      cpu_search_q <= 2'b00;
      inval_q      <= 2'b00;
      datasel0_q   <= 2'b00;
      datasel1_q   <= 2'b00;
      case (state)
        IDLE: begin
          if (pend != 2'b00) begin
            r    <= pick;
            kind <= pick_kind;
            case (pick_kind)
              K_INV: begin
                state   <= INVAL;
                grant_q <= onehot(pick);
                inval_q <= onehot(~pick);
              end
              K_EV: begin
                state  <= MEM;
                perm_q <= onehot(pick);
              end
              default: begin
                state        <= SNOOP;
                cpu_search_q <= onehot(~pick);
                if (pick) boci0_q <= pick_addr;
                else      boci1_q <= pick_addr;
              end
            endcase
          end
        end
        SNOOP: begin
          if (found_o) begin
            state             <= FWD;
            other_proc_data_q <= data_o;
            grant_q           <= onehot(r);
            if (r) datasel1_q <= 2'b01;
            else   datasel0_q <= 2'b01;
            if (kind == K_WR) inval_q <= onehot(~r);
          end else begin
            state  <= MEM;
            perm_q <= onehot(r);
          end
        end
        FWD:   state <= DONE;
        MEM: begin
          if (bus.u_rdy) begin
            state  <= DONE;
            perm_q <= 2'b00;
          end
        end
        INVAL: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q | (((state == MEM) && bus.u_rdy) ? onehot(r) : 2'b00);
  assign bus.cpu_search                = cpu_search_q;
  assign bus.boci0                     = boci0_q;
  assign bus.boci1                     = boci1_q;
  assign bus.other_proc_data           = other_proc_data_q;
  assign bus.cpu_datasel0              = datasel0_q;
  assign bus.cpu_datasel1              = datasel1_q;
  assign bus.cpu_dmem_permission       = perm_q;
  assign bus.invalidate_from_other_cpu = inval_q;

endmodule
